// File: rtl/cmd_sender.sv
// Purpose : fetch one stored BLE command from the byte-wide command memory and stream it into the UART TX FIFO.
// Latency : start sampled at E0; first FIFO write at the end of cycle 5, n-byte command done in cycle 3n+3 with no stalls.
// Backpress: PUSH holds while i_tx_full is high; one byte per three cycles otherwise.
//
// Optional feature macro: CMD_SENDER_TIMEOUT_EN -- abort with error_code 3 after TIMEOUT_CYCLES stalled PUSH cycles.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   i_start, i_cmd_sel    send request (sampled only in IDLE) and command index
//   o_mem_rd_en/o_mem_addr/i_mem_rdata   registered memory read port, data one cycle after strobe
//   i_tx_full, o_tx_wr_en, o_tx_data     TX FIFO write side
//   o_busy, o_done, o_error_code, o_error_pulse   status
//   error codes: 0 none, 1 bad select, 2 no terminator, 3 TX timeout
module cmd_sender #(
    parameter int CMD_WIDTH      = 32,
    parameter int CMD_DEPTH      = 16,
    parameter int ADDR_WIDTH     = $clog2(CMD_WIDTH*CMD_DEPTH),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_start,
    input  logic [$clog2(CMD_DEPTH)-1:0] i_cmd_sel,
    output logic                         o_mem_rd_en,
    output logic [ADDR_WIDTH-1:0]        o_mem_addr,
    input  logic [7:0]                   i_mem_rdata,
    input  logic                         i_tx_full,
    output logic                         o_tx_wr_en,
    output logic [7:0]                   o_tx_data,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [1:0]                   o_error_code,
    output logic                         o_error_pulse
);
    localparam int SEL_W = $clog2(CMD_DEPTH);
    localparam int IDX_W = $clog2(CMD_WIDTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RD_CNT    = 3'd1;
    localparam logic [2:0] S_WAIT_CNT  = 3'd2;
    localparam logic [2:0] S_RD_BYTE   = 3'd3;
    localparam logic [2:0] S_WAIT_BYTE = 3'd4;
    localparam logic [2:0] S_PUSH      = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    localparam logic [7:0]       LF      = 8'h0A;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(CMD_WIDTH-1);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0]            r_state;
    logic [SEL_W-1:0]      r_sel;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_mem_rd_en;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [7:0]            r_tx_data;
    logic [1:0]            r_error_code;

    logic [2:0]            w_next_state;
    logic [IDX_W-1:0]      w_next_idx;
    logic                  w_err_set;
    logic [1:0]            w_err_val;
    logic                  w_tx_wr_en;
    logic                  w_bad_sel;
    logic                  w_timeout;
    logic [ADDR_WIDTH-1:0] w_byte_addr;

    assign w_tx_wr_en = (r_state == S_PUSH) && !i_tx_full;

    // The last slot is reserved, so an index at CMD_DEPTH-1 is rejected even if the count allows it.
    assign w_bad_sel = (32'(r_sel) >= 32'(i_mem_rdata)) || (32'(r_sel) >= 32'(CMD_DEPTH-1));

    // Address of the byte about to be read, built from the index the FSM is moving to.
    assign w_byte_addr = ADDR_WIDTH'(r_sel) * ADDR_WIDTH'(CMD_WIDTH)
                       + ADDR_WIDTH'(1) + ADDR_WIDTH'(w_next_idx);

`ifdef CMD_SENDER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES+1);
    logic [TO_W-1:0] r_stall_cnt;

    // Counts consecutive stalled PUSH cycles; any write or leaving PUSH clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_PUSH) && i_tx_full) begin
            r_stall_cnt <= r_stall_cnt + TO_W'(1);
        end else begin
            r_stall_cnt <= '0;
        end
    end

    // Fires on the stalled cycle that brings the count to TIMEOUT_CYCLES.
    assign w_timeout = (r_state == S_PUSH) && i_tx_full
                    && (r_stall_cnt == TO_W'(TIMEOUT_CYCLES-1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_err_set    = 1'b0;
        w_err_val    = 2'd0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_RD_CNT;
                    w_next_idx   = '0;
                end
            end
            S_RD_CNT:  w_next_state = S_WAIT_CNT;
            S_WAIT_CNT: begin
                if (w_bad_sel) begin
                    w_next_state = S_IDLE;
                    w_err_set    = 1'b1;
                    w_err_val    = 2'd1;
                end else begin
                    w_next_state = S_RD_BYTE;
                end
            end
            S_RD_BYTE:   w_next_state = S_WAIT_BYTE;
            S_WAIT_BYTE: w_next_state = S_PUSH;
            S_PUSH: begin
                if (w_tx_wr_en) begin
                    if (r_tx_data == LF) begin
                        w_next_state = S_DONE;
                    end else if (r_idx == IDX_MAX) begin
                        w_next_state = S_IDLE;
                        w_err_set    = 1'b1;
                        w_err_val    = 2'd2;
                    end else begin
                        w_next_state = S_RD_BYTE;
                        w_next_idx   = r_idx + IDX_W'(1);
                    end
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                    w_err_set    = 1'b1;
                    w_err_val    = 2'd3;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_sel        <= '0;
            r_idx        <= '0;
            r_mem_rd_en  <= 1'b0;
            r_mem_addr   <= '0;
            r_tx_data    <= '0;
            r_error_code <= '0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            // Strobe and address are registered so they line up with the RD_* state cycle.
            r_mem_rd_en <= (w_next_state == S_RD_CNT) || (w_next_state == S_RD_BYTE);
            if (w_next_state == S_RD_CNT) begin
                r_mem_addr <= '0;
            end else if (w_next_state == S_RD_BYTE) begin
                r_mem_addr <= w_byte_addr;
            end
            if ((r_state == S_IDLE) && i_start) begin
                r_sel        <= i_cmd_sel;
                r_error_code <= 2'd0;
            end
            if (w_err_set) begin
                r_error_code <= w_err_val;
            end
            if (r_state == S_WAIT_BYTE) begin
                r_tx_data <= i_mem_rdata;
            end
        end
    end

    assign o_mem_rd_en   = r_mem_rd_en;
    assign o_mem_addr    = r_mem_addr;
    assign o_tx_wr_en    = w_tx_wr_en;
    assign o_tx_data     = r_tx_data;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_DONE);
    assign o_error_code  = r_error_code;
    assign o_error_pulse = w_err_set;
endmodule

// File: tb/tb_cmd_sender.sv
module tb_cmd_sender;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] cmd_sel = '0;
    logic       mem_rd_en;
    logic [8:0] mem_addr;
    logic [7:0] mem_rdata = '0;
    logic       tx_full;
    logic       tx_wr_en;
    logic [7:0] tx_data;
    logic       busy, done, error_pulse;
    logic [1:0] error_code;

    logic       full_drv = 1'b0;
    logic       rnd_full = 1'b0;
    logic       rand_full = 1'b0;
    assign tx_full = rand_full ? rnd_full : full_drv;

    cmd_sender #(.CMD_WIDTH(32), .CMD_DEPTH(16), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_cmd_sel(cmd_sel),
        .o_mem_rd_en(mem_rd_en), .o_mem_addr(mem_addr), .i_mem_rdata(mem_rdata),
        .i_tx_full(tx_full), .o_tx_wr_en(tx_wr_en), .o_tx_data(tx_data),
        .o_busy(busy), .o_done(done), .o_error_code(error_code), .o_error_pulse(error_pulse)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:511];
    int tn = 0;
    int tf = 0;
    int cyc = 0;
    int t0 = 0;
    int busy_fall = -1;
    logic prev_busy = 1'b0;
    logic [7:0] wr_q[$];
    logic [7:0] exp_q[$];
    int done_q[$];
    int errp_q[$];

    always @(posedge clk) cyc++;

    // Synchronous-read command memory.
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    always @(posedge clk) begin
        #1;
        rnd_full = ($urandom_range(0, 2) == 0);
    end

    // Mid-cycle monitor; cycle numbers are relative to the start-sampling edge E0.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_wr_en) wr_q.push_back(tx_data);
            if (done) done_q.push_back(cyc - t0 + 1);
            if (error_pulse) errp_q.push_back(cyc - t0 + 1);
            if (prev_busy && !busy && busy_fall < 0) busy_fall = cyc - t0 + 1;
        end
        prev_busy = busy;
    end

    // Reference: the bytes a command should produce and the resulting error code.
    function automatic int model(input int sel);
        logic [7:0] b;
        exp_q.delete();
        if (sel >= int'(mem[0]) || sel >= 15) return 1;
        for (int i = 0; i < 32; i++) begin
            b = mem[sel*32 + 1 + i];
            exp_q.push_back(b);
            if (b == 8'h0A) return 0;
        end
        return 2;
    endfunction

    function automatic string qs(input logic [7:0] q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
        return s;
    endfunction

    function automatic bit same(input logic [7:0] a[$], input logic [7:0] b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic fill_slot(input int s, input logic [7:0] v);
        for (int i = 0; i < 32; i++) mem[s*32 + 1 + i] = v;
    endtask

    task automatic put4(input int s, input logic [31:0] w);
        fill_slot(s, 8'h20);
        for (int i = 0; i < 4; i++) mem[s*32 + 1 + i] = w[31-8*i -: 8];
    endtask

    task automatic start_cmd(input int sel);
        @(posedge clk); #1;
        wr_q.delete(); done_q.delete(); errp_q.delete();
        busy_fall = -1;
        cmd_sel = 4'(sel);
        start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 2000; i++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        tn++;
        if (busy !== 1'b0) begin
            tf++;
            $display("FAIL %s_timeout: busy=%0b still after 2000 cycles, need 0", nm, busy);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tn++;
        if ({busy, done, mem_rd_en, mem_addr, tx_wr_en, tx_data, error_code, error_pulse} !== '0) begin
            tf++;
            $display("FAIL reset_outputs: busy=%0b done=%0b rd=%0b addr=%0h wr=%0b data=%0h code=%0d pulse=%0b, need all 0",
                     busy, done, mem_rd_en, mem_addr, tx_wr_en, tx_data, error_code, error_pulse);
        end
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tn++;
        if ({busy, mem_rd_en, tx_wr_en, error_code} !== '0) begin
            tf++;
            $display("FAIL reset_idle: busy=%0b rd=%0b wr=%0b code=%0d, need all 0", busy, mem_rd_en, tx_wr_en, error_code);
        end
    endtask

    task automatic test_basic();
        int err;
        mem[0] = 8'd7;
        put4(0, 32'h41540D0A);
        start_cmd(0);
        wait_idle("basic");
        err = model(0);
        tn++;
        if (!same(wr_q, exp_q)) begin
            tf++;
            $display("FAIL basic_bytes: got %s need %s", qs(wr_q), qs(exp_q));
        end
        tn++;
        if (done_q.size() != 1 || done_q[0] != 15) begin
            tf++;
            $display("FAIL basic_done: got %0d pulses first@%0d, need 1 pulse @15", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
        end
        tn++;
        if (busy_fall != 16) begin
            tf++;
            $display("FAIL basic_busy_fall: got cycle %0d, need 16", busy_fall);
        end
        tn++;
        if (error_code !== 2'(err) || errp_q.size() != 0) begin
            tf++;
            $display("FAIL basic_error: code=%0d pulses=%0d, need code %0d and 0 pulses", error_code, errp_q.size(), err);
        end
    endtask

    task automatic test_bad_sel();
        int sels[2] = '{7, 15};
        int err;
        mem[0] = 8'd7;
        foreach (sels[k]) begin
            start_cmd(sels[k]);
            wait_idle("bad_sel");
            err = model(sels[k]);
            tn++;
            if (wr_q.size() != 0 || done_q.size() != 0) begin
                tf++;
                $display("FAIL bad_sel%0d_writes: got %0d writes %0d done, need 0 and 0", sels[k], wr_q.size(), done_q.size());
            end
            tn++;
            if (error_code !== 2'(err)) begin
                tf++;
                $display("FAIL bad_sel%0d_code: got %0d need %0d", sels[k], error_code, err);
            end
            tn++;
            if (errp_q.size() != 1 || errp_q[0] != 2) begin
                tf++;
                $display("FAIL bad_sel%0d_pulse: got %0d pulses first@%0d, need 1 @2", sels[k], errp_q.size(), (errp_q.size() > 0) ? errp_q[0] : -1);
            end
        end
        repeat (4) @(posedge clk);
        #1;
        tn++;
        if (error_code !== 2'd1) begin
            tf++;
            $display("FAIL bad_sel_hold: got code %0d need 1", error_code);
        end
    endtask

    task automatic test_no_term();
        int err;
        mem[0] = 8'd7;
        fill_slot(2, 8'h41);
        start_cmd(2);
        wait_idle("no_term");
        err = model(2);
        tn++;
        if (!same(wr_q, exp_q)) begin
            tf++;
            $display("FAIL no_term_bytes: got %0d bytes need %0d: %s", wr_q.size(), exp_q.size(), qs(wr_q));
        end
        tn++;
        if (error_code !== 2'(err) || done_q.size() != 0) begin
            tf++;
            $display("FAIL no_term_code: code=%0d done=%0d, need code %0d done 0", error_code, done_q.size(), err);
        end
        tn++;
        if (errp_q.size() != 1 || errp_q[0] != 3*31 + 5 || busy_fall != 3*31 + 6) begin
            tf++;
            $display("FAIL no_term_timing: pulses=%0d first@%0d busy_fall=%0d, need 1 @98 and 99",
                     errp_q.size(), (errp_q.size() > 0) ? errp_q[0] : -1, busy_fall);
        end
    endtask

    task automatic test_stall();
        int err;
        mem[0] = 8'd7;
        put4(0, 32'h41540D0A);
        start_cmd(0);
        repeat (7) @(posedge clk);
        #1 full_drv = 1'b1;
        repeat (5) @(posedge clk);
        #1 full_drv = 1'b0;
        wait_idle("stall");
        err = model(0);
        tn++;
        if (!same(wr_q, exp_q)) begin
            tf++;
            $display("FAIL stall_bytes: got %s need %s", qs(wr_q), qs(exp_q));
        end
        tn++;
        if (done_q.size() != 1 || done_q[0] != 20 || error_code !== 2'(err)) begin
            tf++;
            $display("FAIL stall_done: pulses=%0d first@%0d code=%0d, need 1 @20 code %0d",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, error_code, err);
        end
    endtask

    task automatic test_reset_mid();
        int err;
        mem[0] = 8'd7;
        put4(0, 32'h41540D0A);
        err = model(0);
        start_cmd(0);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        tn++;
        if ({busy, done, mem_rd_en, mem_addr, tx_wr_en, tx_data, error_code, error_pulse} !== '0) begin
            tf++;
            $display("FAIL reset_mid_outputs: busy=%0b rd=%0b addr=%0h wr=%0b data=%0h code=%0d, need all 0",
                     busy, mem_rd_en, mem_addr, tx_wr_en, tx_data, error_code);
        end
        tn++;
        if (wr_q.size() != 2 || wr_q[0] !== exp_q[0] || wr_q[1] !== exp_q[1]) begin
            tf++;
            $display("FAIL reset_mid_partial: got %s need first two of %s", qs(wr_q), qs(exp_q));
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        start_cmd(0);
        wait_idle("reset_resend");
        tn++;
        if (!same(wr_q, exp_q) || done_q.size() != 1) begin
            tf++;
            $display("FAIL reset_resend: got %s (%0d done) need %s", qs(wr_q), done_q.size(), qs(exp_q));
        end
    endtask

    task automatic test_back_to_back();
        int err0, err1;
        logic [7:0] exp0[$];
        mem[0] = 8'd7;
        put4(0, 32'h41540D0A);
        put4(1, 32'h4F4B0D0A);
        err0 = model(0);
        exp0 = exp_q;
        start_cmd(0);
        repeat (5) @(posedge clk);
        #1; start = 1'b1; cmd_sel = 4'd1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        tn++;
        if (busy !== 1'b0) begin
            tf++;
            $display("FAIL b2b_start_in_done: busy=%0b in cycle 17, need 0", busy);
        end
        tn++;
        if (!same(wr_q, exp0) || error_code !== 2'(err0) || done_q.size() != 1 || done_q[0] != 15) begin
            tf++;
            $display("FAIL b2b_first: got %s code=%0d done=%0d, need %s code %0d done 1 @15",
                     qs(wr_q), error_code, done_q.size(), qs(exp0), err0);
        end
        err1 = model(1);
        start_cmd(1);
        wait_idle("b2b_second");
        tn++;
        if (!same(wr_q, exp_q) || error_code !== 2'(err1) || done_q.size() != 1) begin
            tf++;
            $display("FAIL b2b_second: got %s code=%0d done=%0d, need %s code %0d", qs(wr_q), error_code, done_q.size(), qs(exp_q), err1);
        end
    endtask

    task automatic test_random();
        int sel, len, err;
        rand_full = 1'b1;
        for (int it = 0; it < 20; it++) begin
            mem[0] = 8'($urandom_range(0, 16));
            for (int s = 0; s < 15; s++) begin
                len = $urandom_range(1, 32);
                for (int i = 0; i < 32; i++) begin
                    mem[s*32 + 1 + i] = 8'($urandom_range(0, 255));
                    if (mem[s*32 + 1 + i] == 8'h0A) mem[s*32 + 1 + i] = 8'h0B;
                end
                if ($urandom_range(0, 5) != 0) mem[s*32 + len] = 8'h0A;
            end
            sel = $urandom_range(0, 15);
            err = model(sel);
            start_cmd(sel);
            wait_idle("random");
            tn++;
            if (!same(wr_q, exp_q)) begin
                tf++;
                $display("FAIL random%0d_bytes: sel=%0d got %s need %s", it, sel, qs(wr_q), qs(exp_q));
            end
            tn++;
            if (error_code !== 2'(err) || done_q.size() != ((err == 0) ? 1 : 0) || errp_q.size() != ((err == 0) ? 0 : 1)) begin
                tf++;
                $display("FAIL random%0d_status: sel=%0d code=%0d done=%0d errp=%0d, need code %0d",
                         it, sel, error_code, done_q.size(), errp_q.size(), err);
            end
        end
        rand_full = 1'b0;
    endtask

`ifdef CMD_SENDER_TIMEOUT_EN
    task automatic test_timeout();
        mem[0] = 8'd7;
        put4(0, 32'h41540D0A);
        full_drv = 1'b1;
        start_cmd(0);
        wait_idle("timeout");
        full_drv = 1'b0;
        tn++;
        if (wr_q.size() != 0 || error_code !== 2'd3) begin
            tf++;
            $display("FAIL timeout_code: writes=%0d code=%0d, need 0 writes code 3", wr_q.size(), error_code);
        end
        tn++;
        if (errp_q.size() != 1 || errp_q[0] != 12 || busy_fall != 13) begin
            tf++;
            $display("FAIL timeout_timing: pulses=%0d first@%0d busy_fall=%0d, need 1 @12 and 13",
                     errp_q.size(), (errp_q.size() > 0) ? errp_q[0] : -1, busy_fall);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        test_reset();
        test_basic();
        test_bad_sel();
        test_no_term();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef CMD_SENDER_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tn, tf);
        $finish;
    end
endmodule
